// File: rtl/cga_vid_pkg.sv
// Shared defaults for the CGA overscan border path.
package cga_vid_pkg;

  localparam int unsigned PIX_W_DEF   = 4;
  localparam int unsigned HBORDER_DEF = 8;
  localparam int unsigned VBORDER_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 11;

  // Extra sum bits needed to detect overflow when adding a border to a counter edge.
  localparam int unsigned SAT_GUARD_W = 1;

endpackage

// File: rtl/cga_span_meas.sv
// Records first and last+1 counter values of an enable within a period delimited by a restart strobe.
// The partial period seen before the first restart after reset is discarded.
module cga_span_meas
  import cga_vid_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter bit          STICKY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             restart,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] first,
  output logic [CNT_W-1:0] last,
  output logic             valid
);

  logic             armed_q, armed_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cur_first_q, cur_first_d;
  logic [CNT_W-1:0] cur_last_q, cur_last_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic             valid_q, valid_d;

  logic             en_eff;
  logic             seen_nxt;
  logic [CNT_W-1:0] first_nxt;
  logic [CNT_W-1:0] last_nxt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  // The restart tick still belongs to the closing period, so its enable is folded in before commit.
  always_comb begin
    armed_d     = armed_q;
    seen_d      = seen_q;
    cur_first_d = cur_first_q;
    cur_last_d  = cur_last_q;
    first_d     = first_q;
    last_d      = last_q;
    valid_d     = valid_q;
    en_eff      = en & armed_q;
    seen_nxt    = seen_q | en_eff;
    first_nxt   = (en_eff && !seen_q) ? cnt : cur_first_q;
    last_nxt    = en_eff ? cnt_inc : cur_last_q;
    if (ce) begin
      if (restart) begin
        armed_d = 1'b1;
        seen_d  = 1'b0;
        if (armed_q) begin
          valid_d = seen_nxt || (STICKY && valid_q);
          if (seen_nxt) begin
            first_d = first_nxt;
            last_d  = last_nxt;
          end
        end
      end else begin
        seen_d      = seen_nxt;
        cur_first_d = first_nxt;
        cur_last_d  = last_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q     <= 1'b0;
      seen_q      <= 1'b0;
      cur_first_q <= '0;
      cur_last_q  <= '0;
      first_q     <= '0;
      last_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      armed_q     <= armed_d;
      seen_q      <= seen_d;
      cur_first_q <= cur_first_d;
      cur_last_q  <= cur_last_d;
      first_q     <= first_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
    end
  end

  assign first = first_q;
  assign last  = last_q;
  assign valid = valid_q;

endmodule

// File: rtl/cga_overscan_port.sv
// Inserts a colored overscan border around the measured active area of a CGA-style video stream.
// Border geometry comes from the previous line (horizontal) and previous frame (vertical).
module cga_overscan_port
  import cga_vid_pkg::*;
#(
  parameter int unsigned PIX_W   = PIX_W_DEF,
  parameter int unsigned HBORDER = HBORDER_DEF,
  parameter int unsigned VBORDER = VBORDER_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             busreset,
  input  logic             pix_ce,
  input  logic [PIX_W-1:0] video_in,
  input  logic             de_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [PIX_W-1:0] border_color,
  input  logic             overscan_en,
  output logic [PIX_W-1:0] video_out,
  output logic             de_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             border_active
);

  localparam int unsigned      SUM_W   = CNT_W + SAT_GUARD_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HB      = CNT_W'(HBORDER);
  localparam logic [CNT_W-1:0] VB      = CNT_W'(VBORDER);

  logic             hs_prev_q, hs_prev_d;
  logic             vs_prev_q, vs_prev_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic [PIX_W-1:0] video_out_q, video_out_d;
  logic             de_out_q, de_out_d;
  logic             hsync_out_q, hsync_out_d;
  logic             vsync_out_q, vsync_out_d;
  logic             border_active_q, border_active_d;

  logic             h_rise, v_rise, border_c;
  logic [CNT_W-1:0] hcnt_inc, vcnt_inc;
  logic [CNT_W-1:0] h_start, h_end, v_first, v_last;
  logic             h_valid, frame_valid;

  // Band is [max(0, lo_edge-bord), min(hi_edge+bord, CNT_MAX)).
  function automatic logic in_band(input logic [CNT_W-1:0] c,
                                   input logic [CNT_W-1:0] lo_edge,
                                   input logic [CNT_W-1:0] hi_edge,
                                   input logic [CNT_W-1:0] bord);
    logic [CNT_W-1:0] lo;
    logic [CNT_W-1:0] hi;
    logic [SUM_W-1:0] sum;
    lo  = (lo_edge >= bord) ? lo_edge - bord : '0;
    sum = SUM_W'(hi_edge) + SUM_W'(bord);
    hi  = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    return (c >= lo) && (c < hi);
  endfunction

  assign h_rise   = hsync_in & ~hs_prev_q;
  assign v_rise   = vsync_in & ~vs_prev_q;
  assign hcnt_inc = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + CNT_W'(1);
  assign vcnt_inc = (vcnt_q == CNT_MAX) ? vcnt_q : vcnt_q + CNT_W'(1);

  // Horizontal span holds its last result across blank lines so border lines above/below have a width.
  cga_span_meas #(.CNT_W(CNT_W), .STICKY(1'b1)) u_hspan (
    .clk     (clk),
    .rst     (busreset),
    .ce      (pix_ce),
    .restart (h_rise),
    .en      (de_in),
    .cnt     (hcnt_q),
    .first   (h_start),
    .last    (h_end),
    .valid   (h_valid)
  );

  cga_span_meas #(.CNT_W(CNT_W), .STICKY(1'b0)) u_vspan (
    .clk     (clk),
    .rst     (busreset),
    .ce      (pix_ce),
    .restart (v_rise),
    .en      (de_in),
    .cnt     (vcnt_q),
    .first   (v_first),
    .last    (v_last),
    .valid   (frame_valid)
  );

  // Syncs and source enable veto the border outright.
  assign border_c = overscan_en & frame_valid & h_valid
                  & in_band(hcnt_q, h_start, h_end, HB)
                  & in_band(vcnt_q, v_first, v_last, VB)
                  & ~de_in & ~hsync_in & ~vsync_in;

  always_comb begin
    hs_prev_d       = hs_prev_q;
    vs_prev_d       = vs_prev_q;
    hcnt_d          = hcnt_q;
    vcnt_d          = vcnt_q;
    video_out_d     = video_out_q;
    de_out_d        = de_out_q;
    hsync_out_d     = hsync_out_q;
    vsync_out_d     = vsync_out_q;
    border_active_d = border_active_q;
    if (pix_ce) begin
      hs_prev_d       = hsync_in;
      vs_prev_d       = vsync_in;
      hcnt_d          = h_rise ? '0 : hcnt_inc;
      vcnt_d          = v_rise ? '0 : (h_rise ? vcnt_inc : vcnt_q);
      video_out_d     = border_c ? border_color : (de_in ? video_in : '0);
      de_out_d        = de_in | border_c;
      hsync_out_d     = hsync_in;
      vsync_out_d     = vsync_in;
      border_active_d = border_c;
    end
  end

  always_ff @(posedge clk or posedge busreset) begin
    if (busreset) begin
      hs_prev_q       <= 1'b0;
      vs_prev_q       <= 1'b0;
      hcnt_q          <= '0;
      vcnt_q          <= '0;
      video_out_q     <= '0;
      de_out_q        <= 1'b0;
      hsync_out_q     <= 1'b0;
      vsync_out_q     <= 1'b0;
      border_active_q <= 1'b0;
    end else begin
      hs_prev_q       <= hs_prev_d;
      vs_prev_q       <= vs_prev_d;
      hcnt_q          <= hcnt_d;
      vcnt_q          <= vcnt_d;
      video_out_q     <= video_out_d;
      de_out_q        <= de_out_d;
      hsync_out_q     <= hsync_out_d;
      vsync_out_q     <= vsync_out_d;
      border_active_q <= border_active_d;
    end
  end

  assign video_out     = video_out_q;
  assign de_out        = de_out_q;
  assign hsync_out     = hsync_out_q;
  assign vsync_out     = vsync_out_q;
  assign border_active = border_active_q;

endmodule
